// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment display driver.
// Patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'h7F;
    localparam seg7_t SEG_MINUS = 7'h3F;

    localparam seg7_t SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    localparam int unsigned MAX_DISP = 999;

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low 7-segment pattern; non-decimal codes give a blank digit.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output seg7_t      seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (digit < 4'd10) begin
            seg = SEG_DIGIT[digit];
        end
    end

endmodule

// File: rtl/binary_to_7seg.sv
// Registered signed-binary to sign + 3-digit 7-segment driver (TC or SM input).
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros in the hundreds/tens digits.
module binary_to_7seg
    import seg7_pkg::*;
#(
    parameter int unsigned W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] bin,
    input  logic         tc_mode,
    output seg7_t        seg_sign,
    output seg7_t        seg_d2,
    output seg7_t        seg_d1,
    output seg7_t        seg_d0,
    output logic         too_large
);

    logic [W:0]  bin_ext;
    logic [W:0]  mag_tc;
    logic [16:0] mag;
    logic        neg;
    logic        too_large_d;
    logic [11:0] bcd;
    logic [3:0]  code2, code1, code0;
    seg7_t       pat2, pat1, pat0;

    // One extra bit so that negating the most negative TC value stays positive.
    always_comb begin
        bin_ext = {bin[W-1], bin};
        mag_tc  = bin[W-1] ? -bin_ext : bin_ext;
        mag     = '0;
        if (tc_mode) begin
            mag[W:0] = mag_tc;
        end else begin
            mag[W-2:0] = bin[W-2:0];
        end
        neg         = bin[W-1] && (mag != '0);
        too_large_d = 32'(mag) > MAX_DISP;
    end

    // Double dabble over the low 10 bits; only consulted when mag <= 999.
    always_comb begin
        bcd = '0;
        for (int i = 9; i >= 0; i--) begin
            if (bcd[3:0] >= 4'd5) bcd[3:0] = bcd[3:0] + 4'd3;
            if (bcd[7:4] >= 4'd5) bcd[7:4] = bcd[7:4] + 4'd3;
            if (bcd[11:8] >= 4'd5) bcd[11:8] = bcd[11:8] + 4'd3;
            bcd = {bcd[10:0], mag[i]};
        end
    end

    // Code 4'hF decodes to a blank digit.
    always_comb begin
        code2 = bcd[11:8];
        code1 = bcd[7:4];
        code0 = bcd[3:0];
`ifdef LEADING_ZERO_BLANK_EN
        if (bcd[11:8] == 4'd0) begin
            code2 = 4'hF;
            if (bcd[7:4] == 4'd0) begin
                code1 = 4'hF;
            end
        end
`else
`endif
    end

    seg7_decoder u_dec2 (.digit(code2), .seg(pat2));
    seg7_decoder u_dec1 (.digit(code1), .seg(pat1));
    seg7_decoder u_dec0 (.digit(code0), .seg(pat0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_sign  <= SEG_BLANK;
            seg_d2    <= SEG_BLANK;
            seg_d1    <= SEG_BLANK;
            seg_d0    <= SEG_BLANK;
            too_large <= 1'b0;
        end else if (too_large_d) begin
            seg_sign  <= SEG_MINUS;
            seg_d2    <= SEG_MINUS;
            seg_d1    <= SEG_MINUS;
            seg_d0    <= SEG_MINUS;
            too_large <= 1'b1;
        end else begin
            seg_sign  <= neg ? SEG_MINUS : SEG_BLANK;
            seg_d2    <= pat2;
            seg_d1    <= pat1;
            seg_d0    <= pat0;
            too_large <= 1'b0;
        end
    end

endmodule

// File: tb/tb_binary_to_7seg.sv
// Self-checking bench for binary_to_7seg (W=11) against an arithmetic reference model.
module tb_binary_to_7seg;

    localparam int W = 11;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] bin;
    logic         tc_mode;
    logic [6:0]   seg_sign, seg_d2, seg_d1, seg_d0;
    logic         too_large;

    int errors = 0;
    int checks = 0;

    logic [6:0] digit_pat [10];
    logic [28:0] got;

    binary_to_7seg #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .bin(bin), .tc_mode(tc_mode),
        .seg_sign(seg_sign), .seg_d2(seg_d2), .seg_d1(seg_d1), .seg_d0(seg_d0),
        .too_large(too_large)
    );

    always #5 clk = ~clk;

    assign got = {too_large, seg_sign, seg_d2, seg_d1, seg_d0};

    // Expected {too_large, sign, d2, d1, d0} from the value's decimal digits.
    function automatic logic [28:0] model(input logic [W-1:0] b, input logic tc);
        int v, m, h, t, u;
        logic [6:0] ps, p2, p1, p0;
        if (tc) begin
            v = int'($signed(b));
            m = (v < 0) ? -v : v;
        end else begin
            m = int'(b[W-2:0]);
        end
        if (m > 999) return {1'b1, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        ps = (b[W-1] && m != 0) ? 7'h3F : 7'h7F;
        h = m / 100;
        t = (m / 10) % 10;
        u = m % 10;
        p2 = digit_pat[h];
        p1 = digit_pat[t];
        p0 = digit_pat[u];
`ifdef LEADING_ZERO_BLANK_EN
        if (h == 0) p2 = 7'h7F;
        if (h == 0 && t == 0) p1 = 7'h7F;
`endif
        return {1'b0, ps, p2, p1, p0};
    endfunction

    task automatic test_reset();
        logic [28:0] exp_v;
        exp_v = {1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst_n   = 1'b0;
            bin     = W'($urandom);
            tc_mode = 1'($urandom);
            @(negedge clk);
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL reset[%0d]: got %h required %h", i, got, exp_v);
            end
        end
        // Reset must also override a value that would light digits.
        @(negedge clk);
        rst_n = 1'b1; bin = W'(725); tc_mode = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL reset_mid: got %h required %h", got, exp_v);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [W-1:0] vb [12];
        logic         vm [12];
        logic [28:0]  exp_v;
        vb = '{11'd725, 11'd725, 11'h7FD, 11'b10000000011, 11'd1000, 11'd1000,
               11'h400, 11'd999, 11'h419, 11'h400, 11'd0, 11'h3FF};
        vm = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bin = vb[i]; tc_mode = vm[i];
            exp_v = model(vb[i], vm[i]);
            @(negedge clk);
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL directed[%0d] bin=%h tc=%0b: got %h required %h",
                         i, vb[i], vm[i], got, exp_v);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] b;
        logic         m;
        logic [28:0]  exp_v;
        for (int i = 0; i < 200; i++) begin
            b = W'($urandom);
            // Bias half the samples into the displayable range.
            if (i % 2 == 0) b[9:0] = 10'($urandom_range(0, 999));
            m = 1'($urandom);
            @(negedge clk);
            bin = b; tc_mode = m;
            exp_v = model(b, m);
            @(negedge clk);
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL random[%0d] bin=%h tc=%0b: got %h required %h",
                         i, b, m, got, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [28:0] exp_q [$];
        logic [28:0] exp_v;
        logic [W-1:0] b;
        logic         m;
        @(negedge clk);
        for (int i = 0; i <= 40; i++) begin
            if (i > 0) begin
                exp_v = exp_q.pop_front();
                checks++;
                if (got !== exp_v) begin
                    errors++;
                    $display("FAIL back_to_back[%0d]: got %h required %h", i, got, exp_v);
                end
            end
            if (i < 40) begin
                b = W'($urandom);
                m = 1'($urandom);
                bin = b; tc_mode = m;
                exp_q.push_back(model(b, m));
                @(negedge clk);
            end
        end
    endtask

    initial begin
        digit_pat = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        rst_n   = 1'b0;
        bin     = '0;
        tc_mode = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
